// File: rtl/spi_mem_responder.sv
// -----------------------------------------------------------------------------
// spi_mem_responder
//   SPI mode-0 slave emulating a small serial RAM (READ 0x03 / WRITE 0x02,
//   big-endian address, auto-incrementing byte stream). All SPI inputs are
//   oversampled in the wb_clk domain; no logic is clocked by spi_sck.
//
// Ports
//   wb_clk    in   system clock, rising edge
//   wb_rst    in   asynchronous active-high reset
//   spi_sck   in   SPI clock (mode 0, idles low), asynchronous to wb_clk
//   spi_ss    in   chip select, active low
//   spi_mosi  in   master-to-slave data, MSB first
//   spi_miso  out  slave-to-master data, 0 when no read data is presented
//   wr_stb    out  one-cycle pulse per committed write byte
//   wr_addr   out  memory index of the committed byte (valid with wr_stb)
//   wr_data   out  committed byte (valid with wr_stb)
//   busy      out  high while synchronised spi_ss is low
// -----------------------------------------------------------------------------
module spi_mem_responder #(
  parameter  int MEMSIZE    = 256,
  parameter  int ADDR_BYTES = 2,
  localparam int AW         = $clog2(MEMSIZE)
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          spi_sck,
  input  logic          spi_ss,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  localparam int ABITS = 8 * ADDR_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    RDATA,
    WDATA,
    IGNORE
  } state_t;

  // Synchronisers: sck_q[1] is the synchronised sck, sck_q[2] its previous
  // sample; edges come from comparing those two.
  logic [2:0]       sck_q;
  logic [1:0]       ss_q;
  logic [1:0]       mosi_q;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [ABITS-1:0] shift_q, shift_d;
  logic             rd_q, rd_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [7:0]       tx_q, tx_d;
  logic             miso_q, miso_d;
  logic             wr_stb_q, wr_stb_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             mem_we;
  logic [7:0]       mem_q [MEMSIZE];

  logic             sck_rise, sck_fall, ss_sync;
  logic [ABITS-1:0] shift_in;
  logic [AW-1:0]    ptr_inc, addr_rx;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign ss_sync  = ss_q[1];
  assign shift_in = {shift_q[ABITS-2:0], mosi_q[1]};
  assign ptr_inc  = ptr_q + 1'b1;          // wraps naturally at MEMSIZE
  assign addr_rx  = AW'(shift_in);         // upper address bits are dropped

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      sck_q     <= '0;
      ss_q      <= 2'b11;
      mosi_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      rd_q      <= 1'b0;
      ptr_q     <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      sck_q     <= {sck_q[1:0], spi_sck};
      ss_q      <= {ss_q[0], spi_ss};
      mosi_q    <= {mosi_q[0], spi_mosi};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      rd_q      <= rd_d;
      ptr_q     <= ptr_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are undefined after
  // power-up and survive wb_rst, like the external RAM it stands in for.
  always_ff @(posedge wb_clk) begin
    if (mem_we) mem_q[ptr_q] <= shift_in[7:0];
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    rd_d      = rd_q;
    ptr_d     = ptr_q;
    tx_d      = tx_q;
    miso_d    = 1'b0;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;

    if (ss_sync) begin
      // Deselect aborts whatever was in flight, including partial bytes.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = CMD;
          cnt_d   = '0;
        end
        CMD: if (sck_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = '0;
            unique case (shift_in[7:0])
              8'h03:   begin rd_d = 1'b1; state_d = ADDR;   end
              8'h02:   begin rd_d = 1'b0; state_d = ADDR;   end
              default:                    state_d = IGNORE;
            endcase
          end
        end
        ADDR: if (sck_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'(ABITS - 1)) begin
            cnt_d = '0;
            ptr_d = addr_rx;
            if (rd_q) begin
              // Preload so the MSB goes out on the very next sck fall.
              tx_d    = mem_q[addr_rx];
              state_d = RDATA;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          miso_d = miso_q;
          if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end else if (sck_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              ptr_d = ptr_inc;
              tx_d  = mem_q[ptr_inc];
            end
          end
        end
        WDATA: if (sck_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d     = '0;
            mem_we    = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = shift_in[7:0];
            ptr_d     = ptr_inc;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign spi_miso = miso_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = ~ss_sync;

endmodule

// File: tb/tb_spi_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_mem_responder
//   Drives SPI frames as a mode-0 master and compares write strobes, read data
//   and miso timing against a byte-array model of the memory.
// -----------------------------------------------------------------------------
module tb_spi_mem_responder;

  localparam int MEMSIZE = 256;
  localparam int AW      = 8;

  logic          wb_clk = 1'b0;
  logic          wb_rst, spi_sck, spi_ss, spi_mosi;
  logic          spi_miso, wr_stb, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  spi_mem_responder #(.MEMSIZE(MEMSIZE), .ADDR_BYTES(2)) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .spi_sck  (spi_sck),
    .spi_ss   (spi_ss),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .wr_stb   (wr_stb),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 wb_clk = ~wb_clk;

  int          checks = 0;
  int          errors = 0;
  int          half   = 4;      // sck half period in wb_clk cycles
  logic        exp_prev;        // miso bit the master should currently see
  logic [7:0]  mem_m   [MEMSIZE];
  bit          valid_m [MEMSIZE];
  logic [7:0]  wbuf    [16];
  logic [15:0] wq [$];
  int          stb_pairs = 0;
  logic        prev_stb  = 1'b0;

  // Capture every write strobe, and flag back-to-back strobes.
  always @(negedge wb_clk) begin
    if (wr_stb) wq.push_back({wr_addr, wr_data});
    if (wr_stb && prev_stb) stb_pairs++;
    prev_stb = wr_stb;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One SPI bit: low phase (mosi set at the fall), rise, high phase.
  // With tm set, miso must still hold the old bit 2 cycles after the fall and
  // show the new bit 3 cycles after it.
  task automatic spi_bit(input logic mo, input logic tm, input logic exp_new, output logic mi);
    spi_sck  = 1'b0;
    spi_mosi = mo;
    for (int c = 1; c <= half; c++) begin
      @(negedge wb_clk);
      if (tm && c == 2) check("miso_hold", 32'(spi_miso), 32'(exp_prev));
      if (tm && c == 3) check("miso_edge", 32'(spi_miso), 32'(exp_new));
    end
    mi      = spi_miso;
    spi_sck = 1'b1;
    repeat (half) @(negedge wb_clk);
    exp_prev = exp_new;
  endtask

  task automatic send_byte(input logic [7:0] tx, input logic tm, input logic [7:0] exp,
                           output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      logic b;
      spi_bit(tx[i], tm, exp[i], b);
      rx[i] = b;
    end
  endtask

  task automatic frame_start();
    @(negedge wb_clk);
    spi_ss = 1'b0;
    repeat (half) @(negedge wb_clk);
  endtask

  task automatic frame_end();
    spi_sck = 1'b0;
    repeat (half) @(negedge wb_clk);
    spi_ss = 1'b1;
    repeat (6) @(negedge wb_clk);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr);
    logic [7:0] rx;
    logic [7:0] acc;
    send_byte(cmd, 1'b0, 8'h00, rx);
    acc = rx;
    send_byte(addr[15:8], 1'b0, 8'h00, rx);
    acc = acc | rx;
    send_byte(addr[7:0], 1'b0, 8'h00, rx);
    acc = acc | rx;
    check("hdr_miso_zero", 32'(acc), 32'h0);
  endtask

  // Write n bytes from wbuf starting at addr, then 'partial' stray bits.
  task automatic do_write(input logic [15:0] addr, input int n, input int partial);
    logic [7:0]  rx;
    logic        b;
    int          a;
    logic [15:0] got;
    wq.delete();
    frame_start();
    send_hdr(8'h02, addr);
    for (int i = 0; i < n; i++) send_byte(wbuf[i], 1'b0, 8'h00, rx);
    for (int i = 0; i < partial; i++) spi_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0, b);
    frame_end();
    check("wr_count", 32'(wq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = (int'(addr) + i) % MEMSIZE;
      if (wq.size() > 0) begin
        got = wq.pop_front();
        check("wr_stb_addr_data", 32'(got), 32'({a[7:0], wbuf[i]}));
      end
      mem_m[a]   = wbuf[i];
      valid_m[a] = 1'b1;
    end
    wq.delete();
  endtask

  task automatic do_read(input logic [15:0] addr, input int n, input logic tm);
    logic [7:0] rx;
    logic [7:0] e;
    int         a;
    wq.delete();
    frame_start();
    send_hdr(8'h03, addr);
    exp_prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = (int'(addr) + i) % MEMSIZE;
      e = mem_m[a];
      send_byte(8'($urandom), tm && valid_m[a], e, rx);
      if (valid_m[a]) check("rd_data", 32'(rx), 32'(e));
    end
    frame_end();
    check("rd_no_stb", 32'(wq.size()), 32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rx;
    logic [7:0]  acc;
    logic        b;
    logic [15:0] ra;
    int          n;

    for (int i = 0; i < MEMSIZE; i++) valid_m[i] = 1'b0;
    wb_rst = 1'b1; spi_ss = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; exp_prev = 1'b0;
    repeat (3) @(negedge wb_clk);
    check("rst_miso",    32'(spi_miso), 32'h0);
    check("rst_wr_stb",  32'(wr_stb),   32'h0);
    check("rst_wr_addr", 32'(wr_addr),  32'h0);
    check("rst_wr_data", 32'(wr_data),  32'h0);
    check("rst_busy",    32'(busy),     32'h0);
    wb_rst = 1'b0;
    repeat (3) @(negedge wb_clk);

    // Basic write then read back.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    do_write(16'h0010, 2, 0);
    do_read(16'h0010, 2, 1'b0);

    // Async reset in the middle of a read, after the third data rise.
    frame_start();
    send_hdr(8'h03, 16'h0010);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, 1'b0, b);
    check("pre_rst_miso", 32'(spi_miso), 32'h1);   // bit 5 of 0xA5
    #2 wb_rst = 1'b1;
    #1;
    check("rst_async_miso", 32'(spi_miso), 32'h0);
    check("rst_async_busy", 32'(busy),     32'h0);
    @(negedge wb_clk);
    spi_ss = 1'b1; spi_sck = 1'b0;
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    repeat (4) @(negedge wb_clk);
    do_read(16'h0010, 1, 1'b0);

    // Wrap at the top of memory.
    wbuf[0] = 8'hFF; wbuf[1] = 8'h11;
    do_write(16'h00FF, 2, 0);
    do_read(16'h00FF, 2, 1'b0);

    // Aborted partial write leaves earlier contents alone.
    wbuf[0] = 8'h5A;
    do_write(16'h0020, 1, 0);
    do_write(16'h0020, 0, 5);
    do_read(16'h0020, 1, 1'b0);

    // Unknown command: miso stays low, nothing written, busy tracks ss.
    wq.delete();
    frame_start();
    check("ign_busy_hi", 32'(busy), 32'h1);
    send_byte(8'h9F, 1'b0, 8'h00, rx);
    acc = rx;
    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom), 1'b0, 8'h00, rx);
      acc = acc | rx;
    end
    check("ign_miso_zero", 32'(acc), 32'h0);
    check("ign_busy_frame", 32'(busy), 32'h1);
    frame_end();
    check("ign_busy_lo", 32'(busy), 32'h0);
    check("ign_no_stb", 32'(wq.size()), 32'h0);
    do_read(16'h0010, 2, 1'b0);

    // Minimum sck half period, 8-byte burst with edge timing checks.
    half = 4;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom);
    do_write(16'h0040, 8, 0);
    do_read(16'h0040, 8, 1'b1);

    // Random transactions, random upper address bits and sck rates.
    for (int it = 0; it < 6; it++) begin
      half = $urandom_range(4, 6);
      ra   = 16'($urandom);
      n    = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      do_write(ra, n, $urandom_range(0, 7));
      do_read(ra, n, 1'b1);
    end

    check("stb_never_back_to_back", 32'(stb_pairs), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
